// File: rtl/div_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package div_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;

endpackage

// File: rtl/div_core.sv
// Period counter: counts 0..ratio-1 while running, decodes terminal count and
// the high half of the divided waveform.
module div_core
    import div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         i_run,
    input  logic [W-1:0] i_ratio,
    output logic         o_tc,
    output logic         o_first_half
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;

    assign w_last       = i_ratio - W'(1);
    assign o_tc         = (r_cnt == w_last);
    assign o_first_half = (r_cnt < (i_ratio >> 1));

    // The ratio only ever changes on the same edge that wraps the counter,
    // so comparing against the live ratio never truncates a period.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_cnt <= '0;
        end else if (!i_run || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Divider controller: run/stop FSM, ratio handshake and boundary-aligned
// ratio updates around the div_core period counter.
module div_ctrl
    import div_pkg::*;
#(
    parameter int W           = 4,
    parameter int RESET_RATIO = 3
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         enable,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_ratio,
    output logic         cfg_ready,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] cur_ratio,
    output logic         cfg_err
);

    state_t       r_state;
    logic [W-1:0] r_cur_ratio;
    logic [W-1:0] r_pend_ratio;
    logic         r_cfg_err;

    logic w_run;
    logic w_tc;
    logic w_first_half;
    logic w_xfer;
    logic w_ratio_ok;
    logic w_accept;

    assign w_run      = (r_state != OFF);
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_ratio_ok = (cfg_ratio >= W'(MIN_RATIO));
    assign w_accept   = w_xfer && w_ratio_ok;

    // Outputs are pure decodes of registers; no input reaches them directly.
    assign cfg_ready = (r_state != PEND);
    assign tick      = w_run && w_tc;
    assign div_out   = w_run && w_first_half;
    assign cur_ratio = r_cur_ratio;
    assign cfg_err   = r_cfg_err;

    div_core #(
        .W(W)
    ) u_core (
        .clk          (clk),
        .clear_n      (clear_n),
        .i_run        (w_run),
        .i_ratio      (r_cur_ratio),
        .o_tc         (w_tc),
        .o_first_half (w_first_half)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state      <= OFF;
            r_cur_ratio  <= W'(RESET_RATIO);
            r_pend_ratio <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && !w_ratio_ok;
            case (r_state)
                OFF: begin
                    if (w_accept) begin
                        r_cur_ratio <= cfg_ratio;
                    end
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_tc) begin
                        if (w_accept) begin
                            r_cur_ratio <= cfg_ratio;
                        end
                        r_state <= enable ? RUN : OFF;
                    end else if (w_accept) begin
                        r_pend_ratio <= cfg_ratio;
                        r_state      <= PEND;
                    end
                end
                PEND: begin
                    // Stop requests are honoured only after the held ratio lands.
                    if (w_tc) begin
                        r_cur_ratio <= r_pend_ratio;
                        r_state     <= enable ? RUN : OFF;
                    end
                end
                default: begin
                    r_state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a period-level model.
module tb_div_ctrl;

    localparam int W  = 4;
    localparam int RR = 3;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         enable;
    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         div_out;
    logic         tick;
    logic [W-1:0] cur_ratio;
    logic         cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: running flag, position in period, ratio in force, held ratios.
    bit m_live = 1'b0;
    bit m_on   = 1'b0;
    bit m_err  = 1'b0;
    bit m_xfer;
    bit m_good;
    int m_pos   = 0;
    int m_ratio = RR;
    int m_pend[$];

    div_ctrl #(
        .W           (W),
        .RESET_RATIO (RR)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .div_out   (div_out),
        .tick      (tick),
        .cur_ratio (cur_ratio),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input int n, output int t, output int h, output int nr);
        t  = 0;
        h  = 0;
        nr = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            t  += int'(tick);
            h  += int'(div_out);
            nr += int'(!cfg_ready);
        end
    endtask

    // Behavioural model, advanced on every rising edge from the applied inputs.
    initial forever begin
        @(posedge clk);
        if (!clear_n) begin
            m_on    = 1'b0;
            m_pos   = 0;
            m_ratio = RR;
            m_err   = 1'b0;
            m_pend.delete();
            m_live  = 1'b1;
        end else if (m_live) begin
            m_xfer = cfg_valid && (m_pend.size() == 0);
            m_good = int'(cfg_ratio) >= 2;
            m_err  = m_xfer && !m_good;
            if (m_xfer)
                $display("xfer t=%0t ratio=%0d %s", $time, cfg_ratio, m_good ? "accepted" : "rejected");
            if (!m_on) begin
                if (m_xfer && m_good) m_ratio = int'(cfg_ratio);
                if (enable) begin
                    m_on  = 1'b1;
                    m_pos = 0;
                end
            end else if (m_pos == m_ratio - 1) begin
                if (m_pend.size() > 0) m_ratio = m_pend.pop_front();
                else if (m_xfer && m_good) m_ratio = int'(cfg_ratio);
                m_pos = 0;
                m_on  = enable;
            end else begin
                m_pos++;
                if (m_xfer && m_good) m_pend.push_back(int'(cfg_ratio));
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("tick",      32'(tick),      32'(m_on && (m_pos == m_ratio - 1)));
            check("div_out",   32'(div_out),   32'(m_on && (m_pos < m_ratio / 2)));
            check("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
            check("cfg_err",   32'(cfg_err),   32'(m_err));
            check("cur_ratio", 32'(cur_ratio), 32'(m_ratio));
        end
    end

    initial begin
        int t, h, nr;
        clear_n   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        cyc();
        cyc();
        check("rst_cur_ratio", 32'(cur_ratio), 32'd3);
        check("rst_ready",     32'(cfg_ready), 32'd1);
        check("rst_tick",      32'(tick),      32'd0);
        check("rst_div",       32'(div_out),   32'd0);
        check("rst_err",       32'(cfg_err),   32'd0);

        // Default ratio 3
        clear_n = 1'b1;
        enable  = 1'b1;
        cyc();
        win(9, t, h, nr);
        check("n3_ticks", 32'(t), 32'd3);
        check("n3_high",  32'(h), 32'd3);

        // Ratio 6 offered at cnt=0 is held until the boundary
        cyc();
        cfg_valid = 1'b1;
        cfg_ratio = 4'd6;
        cyc();
        cfg_valid = 1'b0;
        check("pend_ready1", 32'(cfg_ready), 32'd0);
        check("pend_cur1",   32'(cur_ratio), 32'd3);
        cyc();
        check("pend_ready2", 32'(cfg_ready), 32'd0);
        check("pend_tick",   32'(tick),      32'd1);
        check("pend_cur2",   32'(cur_ratio), 32'd3);
        cyc();
        check("n6_cur",   32'(cur_ratio), 32'd6);
        check("n6_ready", 32'(cfg_ready), 32'd1);
        win(6, t, h, nr);
        check("n6_ticks", 32'(t), 32'd1);
        check("n6_high",  32'(h), 32'd3);

        // Ratio 5 offered exactly at terminal count
        cfg_valid = 1'b1;
        cfg_ratio = 4'd5;
        cyc();
        cfg_valid = 1'b0;
        check("n5_cur", 32'(cur_ratio), 32'd5);
        win(5, t, h, nr);
        check("n5_ticks",   32'(t),  32'd1);
        check("n5_high",    32'(h),  32'd2);
        check("n5_no_pend", 32'(nr), 32'd0);

        // Rejected ratios 1 then 0
        cfg_valid = 1'b1;
        cfg_ratio = 4'd1;
        cyc();
        check("err1",     32'(cfg_err),   32'd1);
        check("err1_cur", 32'(cur_ratio), 32'd5);
        cfg_ratio = 4'd0;
        cyc();
        check("err0", 32'(cfg_err), 32'd1);
        cfg_valid = 1'b0;
        cyc();
        check("err_clr",  32'(cfg_err),   32'd0);
        check("err_cur",  32'(cur_ratio), 32'd5);

        // Switch to 4, then stop at cnt=1
        cfg_valid = 1'b1;
        cfg_ratio = 4'd4;
        cyc();
        cfg_valid = 1'b0;
        check("n4_pend_cur", 32'(cur_ratio), 32'd5);
        cyc();
        cyc();
        check("n4_cur", 32'(cur_ratio), 32'd4);
        cyc();
        enable = 1'b0;
        cyc();
        cyc();
        check("stop_last_tick", 32'(tick), 32'd1);
        cyc();
        check("off_tick",  32'(tick),      32'd0);
        check("off_div",   32'(div_out),   32'd0);
        check("off_cur",   32'(cur_ratio), 32'd4);
        check("off_ready", 32'(cfg_ready), 32'd1);
        win(6, t, h, nr);
        check("off_ticks", 32'(t), 32'd0);
        check("off_high",  32'(h), 32'd0);

        // Reset while a ratio 7 is pending at cnt=2
        enable = 1'b1;
        cyc();
        cfg_valid = 1'b1;
        cfg_ratio = 4'd7;
        cyc();
        cfg_valid = 1'b0;
        cyc();
        check("pre_rst_ready", 32'(cfg_ready), 32'd0);
        clear_n   = 1'b0;
        cfg_valid = 1'b1;
        cfg_ratio = 4'd9;
        cyc();
        check("mid_rst_cur",   32'(cur_ratio), 32'd3);
        check("mid_rst_tick",  32'(tick),      32'd0);
        check("mid_rst_div",   32'(div_out),   32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        cyc();
        check("rst_ignores_cfg", 32'(cur_ratio), 32'd3);
        clear_n   = 1'b1;
        cfg_valid = 1'b0;
        cyc();
        win(9, t, h, nr);
        check("post_rst_ticks", 32'(t),         32'd3);
        check("post_rst_cur",   32'(cur_ratio), 32'd3);

        // Randomized traffic, mostly enabled
        for (int i = 0; i < 3000; i++) begin
            clear_n   = ($urandom_range(0, 63) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ratio = 4'($urandom_range(0, 15));
            cyc();
        end
        // Randomized traffic with frequent stop/restart
        for (int i = 0; i < 1500; i++) begin
            clear_n   = ($urandom_range(0, 127) != 0);
            enable    = ($urandom_range(0, 1) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ratio = 4'($urandom_range(0, 15));
            cyc();
        end
        cfg_valid = 1'b0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter W, default 4, width of the ratio and counter fields.
REQ-002 Parameter RESET_RATIO, default 3, the active divide ratio after reset; SHALL be in 2..2^W-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clear_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 cfg_valid  input  1  new ratio offered.
REQ-007 cfg_ratio  input  W  requested divide ratio N.
REQ-008 cfg_ready  output  1  controller can accept a ratio.
REQ-009 div_out  output  1  divided waveform.
REQ-010 tick  output  1  one-cycle pulse per divided period.
REQ-011 cur_ratio  output  W  ratio currently in force.
REQ-012 cfg_err  output  1  one-cycle pulse flagging a rejected ratio.

Function
REQ-013 FSM states: OFF (counter halted), RUN (counting), PEND (counting, new ratio held).
REQ-014 The counter cnt SHALL count 0..cur_ratio-1 in RUN/PEND, incrementing by 1 per clk and wrapping to 0 after cur_ratio-1.
REQ-015 tick SHALL be 1 exactly when state != OFF and cnt == cur_ratio-1; the tick period equals cur_ratio cycles.
REQ-016 div_out SHALL be 1 when state != OFF and cnt < (cur_ratio >> 1); otherwise 0 (N=2: 1 of 2 cycles high; N=5: 2 of 5).
REQ-017 tick, div_out and cfg_ready SHALL be decoded from registered state only, with no combinational path from any input.
REQ-018 A transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in OFF and RUN, and 0 in PEND.
REQ-019 Transfer with cfg_ratio < 2: the value is discarded, state/cur_ratio unchanged, and cfg_err=1 on the next cycle only.
REQ-020 Valid transfer in OFF: cur_ratio takes the value on the next cycle; the state stays OFF.
REQ-021 Valid transfer in RUN when not at terminal count: the value is stored in pend_ratio and the state goes to PEND.
REQ-022 Valid transfer in RUN at terminal count: cur_ratio is updated at this boundary, cnt goes to 0, and the state goes to RUN (or OFF per REQ-025).
REQ-023 In PEND at terminal count: cur_ratio <= pend_ratio, cnt <= 0, and the state goes to RUN (or OFF per REQ-025); cur_ratio SHALL never change mid-period.
REQ-024 OFF with enable=1: go to RUN with cnt=0; the first tick occurs cur_ratio cycles after the transition.
REQ-025 enable=0 in RUN/PEND: counting continues to terminal count, and the state then goes to OFF with cnt=0, after any pending ratio is applied (no truncated period).
REQ-026 enable re-asserted before terminal count cancels the pending stop.

Reset
REQ-027 While clear_n=0 at a clk edge: the state SHALL be OFF, cnt=0, cur_ratio=RESET_RATIO, pend_ratio=0, tick=0, div_out=0, cfg_err=0, and cfg_ready=1 on the following cycle.
REQ-028 A reset mid-period or in PEND SHALL discard the pending ratio and any pending stop, with no tick issued.
REQ-029 cfg_valid and enable SHALL be ignored in any cycle where clear_n=0.

Structure
REQ-030 Shared package div_pkg SHALL hold the FSM state enum (OFF, RUN, PEND) and the constant MIN_RATIO=2.
REQ-031 One sub-module, div_core, SHALL hold cnt and its terminal-count/wrap logic; div_ctrl holds the FSM, handshake and ratio registers.
REQ-032 The design SHALL be fully synchronous, with no derived clocks; div_out is a data signal, not a clock.

Verification
REQ-033 Reset, enable=1, no cfg -> tick every 3 cycles, div_out high 1 of 3, cur_ratio=3.
REQ-034 In RUN at N=3, cfg 6 accepted at cnt=0 -> cfg_ready=0 for 2 cycles; the period following the current one is 6 cycles with div_out high 3; cur_ratio changes only at the boundary.
REQ-035 cfg 5 presented exactly at terminal count -> the next period is 5 cycles, with no PEND state entered.
REQ-036 cfg_ratio=1 and then 0 -> cfg_err pulses once per transfer; the tick cadence is unchanged.
REQ-037 N=4, enable dropped at cnt=1 -> ticks continue to the end of the period, then OFF; outputs are 0 and no further ticks.
REQ-038 clear_n low in PEND at cnt=2 -> all outputs at reset values, cur_ratio=3, and the pending ratio is never applied.
